// File: rtl/complex_div_operand_collector.sv
// Operand collector feeding complex_div: assembles 4-word FP64 groups
// into operand sets and buffers them in a small FIFO with tag/zero flag.
module complex_div_operand_collector #(
  parameter int NUM_OPERANDS = 4,
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 2,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic [WIDTH-1:0]              word_i,
  input  logic                          word_last_i,
  output logic                          div_valid_o,
  input  logic                          div_ready_i,
  output logic [NUM_OPERANDS*WIDTH-1:0] div_operands_o,
  output logic [TAG_WIDTH-1:0]          div_tag_o,
  output logic                          div_zero_o,
  output logic                          err_o,
  output logic                          busy_o
);

  localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = NUM_OPERANDS * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPERANDS - 1);

  // assembly state
  logic [IW-1:0]        idx_q;
  logic [WIDTH-1:0]     part_q [NUM_OPERANDS-1];
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 err_q;

  // fifo state
  logic [OW-1:0]        fifo_ops_q  [DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag_q  [DEPTH];
  logic                 fifo_zero_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [CW-1:0]        count_q;

  logic          at_last;
  logic          full;
  logic          empty;
  logic          xfer;
  logic          frame_ok;
  logic          store;
  logic          push;
  logic          pop;
  logic          frame_err;
  logic          push_zero;
  logic [OW-1:0] push_ops;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign at_last  = (idx_q == LAST_IDX);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

  // a pop in the same cycle never frees a slot for the push
  assign word_ready_o = !at_last || !full;

  assign xfer      = word_valid_i && word_ready_o;
  assign frame_ok  = (word_last_i == at_last);
  assign store     = xfer && frame_ok && !at_last && !flush_i;
  assign push      = xfer && frame_ok && at_last && !flush_i;
  assign frame_err = xfer && !frame_ok && !flush_i;
  assign pop       = !empty && div_ready_i && !flush_i;

  // divisor is zero when both divisor words are +/-0
  assign push_zero =
    (part_q[NUM_OPERANDS-2][WIDTH-2:0] == '0) &&
    (word_i[WIDTH-2:0] == '0);

  // pack stored words plus the incoming last word, index 0 at the LSBs
  always_comb begin
    push_ops = '0;
    for (int i = 0; i < NUM_OPERANDS - 1; i++) begin
      push_ops[i*WIDTH +: WIDTH] = part_q[i];
    end
    push_ops[(NUM_OPERANDS-1)*WIDTH +: WIDTH] = word_i;
  end

  // word index and partial-group storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_OPERANDS - 1; i++) begin
        part_q[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        flush_i:   idx_q <= '0;
        frame_err: idx_q <= '0;
        push:      idx_q <= '0;
        store: begin
          part_q[idx_q] <= word_i;
          idx_q         <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // operation tag counter, survives flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else if (push) begin
      tag_q <= tag_q + 1'b1;
    end
  end

  // sticky framing error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (flush_i) begin
      err_q <= 1'b0;
    end else if (frame_err) begin
      err_q <= 1'b1;
    end
  end

  // fifo pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // fifo entry storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_ops_q[i]  <= '0;
        fifo_tag_q[i]  <= '0;
        fifo_zero_q[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_ops_q[wr_ptr_q]  <= push_ops;
      fifo_tag_q[wr_ptr_q]  <= tag_q;
      fifo_zero_q[wr_ptr_q] <= push_zero;
    end
  end

  // head entry drives the divider; zeros when nothing is queued
  assign div_valid_o    = !empty;
  assign div_operands_o = empty ? '0 : fifo_ops_q[rd_ptr_q];
  assign div_tag_o      = empty ? '0 : fifo_tag_q[rd_ptr_q];
  assign div_zero_o     = !empty && fifo_zero_q[rd_ptr_q];

  assign err_o  = err_q;
  assign busy_o = (idx_q != '0) || !empty;

endmodule
